// File: rtl/if_fetch.sv
// if_fetch -- instruction fetch unit feeding the instruction queue.
//
// Holds the program counter. Fetches 32-bit words from the memory
// controller through a level request / one-cycle done handshake. Pushes each
// word to the instruction queue as a single-cycle IF_S pulse, throttled by
// IQ_full. A flush (clr + clr_pc) redirects fetch. A request that is in
// flight is always allowed to complete, because the controller requires it.
//
// Optional feature: define ICACHE_EN to build a direct-mapped instruction
// cache with 2^ICACHE_IDX one-word lines. Every MC_done fills the line at
// MC_addr. Without ICACHE_EN, every instruction costs one memory transaction.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   rdy               global ready; when low, every register holds
//   clr, clr_pc       flush request and redirect target
//   IQ_full           registered full flag from the instruction queue
//   IF_S, IF_Inst,    push strobe, pushed word and its address (registered)
//   IF_pc
//   MC_req, MC_addr   memory read request (level) and word address (registered)
//   MC_done, MC_data  one-cycle completion pulse and the returned word
module if_fetch #(
  parameter int ICACHE_IDX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic [31:0] clr_pc,
  input  logic        IQ_full,
  output logic        IF_S,
  output logic [31:0] IF_Inst,
  output logic [31:0] IF_pc,
  output logic        MC_req,
  output logic [31:0] MC_addr,
  input  logic        MC_done,
  input  logic [31:0] MC_data
);

  typedef enum logic [1:0] {IDLE, MISS, DRAIN} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [31:0] pc_q, pc_d;
  logic        fb_valid_q, fb_valid_d;
  logic [31:0] fb_pc_q, fb_pc_d;
  logic [31:0] fb_data_q, fb_data_d;
  logic        if_s_q, if_s_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        mc_req_q, mc_req_d;
  logic [31:0] mc_addr_q, mc_addr_d;

  logic        cache_hit;
  logic [31:0] cache_word;
  logic        fb_hit;
  logic        avail;
  logic        can_push;

  // An out-of-range index width would produce a broken cache; reject it at
  // elaboration in either build.
  if (ICACHE_IDX < 1 || ICACHE_IDX > 29) begin : g_bad_idx
    $error("if_fetch: ICACHE_IDX must be in 1..29");
  end

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX;
  localparam int TAG_W = 30 - ICACHE_IDX;

  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];
  logic [LINES-1:0]      line_valid_q, line_valid_d;
  logic [ICACHE_IDX-1:0] rd_idx, wr_idx;
  logic                  fill_en;

  assign rd_idx  = pc_q[ICACHE_IDX+1:2];
  assign wr_idx  = mc_addr_q[ICACHE_IDX+1:2];
  // Any completed transaction fills its line. This includes one whose word is
  // discarded by a flush.
  assign fill_en = rdy && MC_done && (fsm_q != IDLE);

  always_comb begin
    cache_hit  = line_valid_q[rd_idx] && (tag_mem[rd_idx] == pc_q[31:ICACHE_IDX+2]);
    cache_word = data_mem[rd_idx];
  end

  always_comb begin
    line_valid_d = line_valid_q;
    if (fill_en) line_valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) line_valid_q <= '0;
    else     line_valid_q <= line_valid_d;
  end

  // NOTE: the tag/data arrays are deliberately not reset; the per-line valid
  // bits qualify them, which keeps the arrays mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[wr_idx]  <= mc_addr_q[31:ICACHE_IDX+2];
      data_mem[wr_idx] <= MC_data;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_word = '0;
`endif

  assign fb_hit   = fb_valid_q && (fb_pc_q == pc_q);
  assign avail    = fb_hit || cache_hit;
  // IQ_full lags a push by one cycle. Refusing to push straight after a push
  // closes that window.
  assign can_push = !IQ_full && !if_s_q;

  // NOTE: every _d defaults to its _q first, so no path leaves a variable
  // unassigned and no latch is inferred.
  always_comb begin
    fsm_d      = fsm_q;
    pc_d       = pc_q;
    fb_valid_d = fb_valid_q;
    fb_pc_d    = fb_pc_q;
    fb_data_d  = fb_data_q;
    if_s_d     = if_s_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    mc_req_d   = mc_req_q;
    mc_addr_d  = mc_addr_q;

    if (rdy) begin
      if_s_d = 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (clr) begin
            pc_d       = clr_pc;
            fb_valid_d = 1'b0;
          end else if (!avail) begin
            mc_req_d  = 1'b1;
            mc_addr_d = pc_q;
            fsm_d     = MISS;
          end else if (can_push) begin
            if_s_d     = 1'b1;
            if_inst_d  = fb_hit ? fb_data_q : cache_word;
            if_pc_d    = pc_q;
            pc_d       = pc_q + 32'd4;
            fb_valid_d = 1'b0;
          end
        end
        MISS: begin
          if (MC_done) begin
            mc_req_d = 1'b0;
            fsm_d    = IDLE;
            if (clr) begin
              pc_d       = clr_pc;
              fb_valid_d = 1'b0;
            end else begin
              fb_valid_d = 1'b1;
              fb_pc_d    = mc_addr_q;
              fb_data_d  = MC_data;
            end
          end else if (clr) begin
            // The request must stay up until done; finish it in DRAIN.
            pc_d       = clr_pc;
            fb_valid_d = 1'b0;
            fsm_d      = DRAIN;
          end
        end
        DRAIN: begin
          if (clr) pc_d = clr_pc;
          if (MC_done) begin
            mc_req_d = 1'b0;
            fsm_d    = IDLE;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      pc_q       <= '0;
      fb_valid_q <= 1'b0;
      fb_pc_q    <= '0;
      fb_data_q  <= '0;
      if_s_q     <= 1'b0;
      if_inst_q  <= '0;
      if_pc_q    <= '0;
      mc_req_q   <= 1'b0;
      mc_addr_q  <= '0;
    end else begin
      fsm_q      <= fsm_d;
      pc_q       <= pc_d;
      fb_valid_q <= fb_valid_d;
      fb_pc_q    <= fb_pc_d;
      fb_data_q  <= fb_data_d;
      if_s_q     <= if_s_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
      mc_req_q   <= mc_req_d;
      mc_addr_q  <= mc_addr_d;
    end
  end

  assign IF_S    = if_s_q;
  assign IF_Inst = if_inst_q;
  assign IF_pc   = if_pc_q;
  assign MC_req  = mc_req_q;
  assign MC_addr = mc_addr_q;

endmodule
